// File: rtl/queue_ctrl.sv
// Sequencing FSM for the RAM-backed queue: arbitrates one producer and one consumer
// and drives the datapath strobes. All outputs come straight from flops.
module queue_ctrl #(
  parameter bit FAIR_ARB = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push_req,
  input  logic i_pop_req,
  input  logic i_overflow,
  input  logic i_underflow,
  output logic o_push_ack,
  output logic o_pop_valid,
  output logic o_push_err,
  output logic o_pop_err,
  output logic o_busy,
  output logic o_add,
  output logic o_remove,
  output logic o_update,
  output logic o_op_select,
  output logic o_we,
  output logic o_re
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RDATA
  } state_t;

  localparam logic GRANT_PUSH = 1'b0;
  localparam logic GRANT_POP  = 1'b1;

  state_t r_state;
  logic   r_last_grant;
  logic   r_push_ack;
  logic   r_pop_valid;
  logic   r_push_err;
  logic   r_pop_err;
  logic   r_busy;
  logic   r_add;
  logic   r_remove;
  logic   r_update;
  logic   r_op_select;
  logic   r_we;
  logic   r_re;

  logic w_pe;
  logic w_qe;
  logic w_grant_push;
  logic w_grant_pop;

  assign w_pe = i_push_req & ~i_overflow;
  assign w_qe = i_pop_req & ~i_underflow;

  // On a tie, the fair mode hands the grant to whichever side did not win last time.
  assign w_grant_push = w_pe & (~w_qe | (FAIR_ARB == 1'b0) | (r_last_grant == GRANT_POP));
  assign w_grant_pop  = w_qe & ~w_grant_push;

  // Outputs are loaded together with the next state so they line up with it exactly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= GRANT_POP;
      r_push_ack   <= 1'b0;
      r_pop_valid  <= 1'b0;
      r_push_err   <= 1'b0;
      r_pop_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_add        <= 1'b0;
      r_remove     <= 1'b0;
      r_update     <= 1'b0;
      r_op_select  <= 1'b0;
      r_we         <= 1'b0;
      r_re         <= 1'b0;
    end else begin
      r_push_ack  <= 1'b0;
      r_pop_valid <= 1'b0;
      r_push_err  <= 1'b0;
      r_pop_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_add       <= 1'b0;
      r_remove    <= 1'b0;
      r_update    <= 1'b0;
      r_op_select <= 1'b0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_push_err <= i_push_req & i_overflow;
          r_pop_err  <= i_pop_req & i_underflow;
          if (w_grant_push) begin
            r_state      <= S_WRITE;
            r_last_grant <= GRANT_PUSH;
            r_busy       <= 1'b1;
            r_push_ack   <= 1'b1;
            r_we         <= 1'b1;
            r_add        <= 1'b1;
            r_update     <= 1'b1;
          end else if (w_grant_pop) begin
            r_state      <= S_READ;
            r_last_grant <= GRANT_POP;
            r_busy       <= 1'b1;
            r_re         <= 1'b1;
            r_remove     <= 1'b1;
            r_update     <= 1'b1;
            r_op_select  <= 1'b1;
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
        end
        S_READ: begin
          // The RAM word appears one cycle after re, so validity is flagged in RDATA.
          r_state     <= S_RDATA;
          r_busy      <= 1'b1;
          r_pop_valid <= 1'b1;
        end
        S_RDATA: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_push_ack  = r_push_ack;
  assign o_pop_valid = r_pop_valid;
  assign o_push_err  = r_push_err;
  assign o_pop_err   = r_pop_err;
  assign o_busy      = r_busy;
  assign o_add       = r_add;
  assign o_remove    = r_remove;
  assign o_update    = r_update;
  assign o_op_select = r_op_select;
  assign o_we        = r_we;
  assign o_re        = r_re;

endmodule

// File: doc/queue_ctrl.md
# queue_ctrl

Sequencing FSM for the RAM-backed queue datapath. Accepts push/pop requests from one producer and one consumer, arbitrates between them, and drives the datapath strobes `add`, `remove`, `update`, `op_select`, `we` and `re` in the required order. Guards against overflow and underflow using the datapath's status flags, and signals read-data validity and rejected requests back to the requesters.

## Interface
- `FAIR_ARB`, default 1: 1 = alternate grants on simultaneous eligible push/pop; 0 = push always wins.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `push_req` in 1: producer request, level; held with data stable until `push_ack` or `push_err`.
- `pop_req` in 1: consumer request, level; held until `pop_valid` or `pop_err`.
- `overflow` in 1: datapath full flag (count == all ones; capacity 2^ADDR_WIDTH−1).
- `underflow` in 1: datapath empty flag (count == 0).
- `push_ack` out 1: write performed this cycle.
- `pop_valid` out 1: datapath `data_out` holds the popped word this cycle.
- `push_err` out 1: one-cycle pulse, push rejected (full).
- `pop_err` out 1: one-cycle pulse, pop rejected (empty).
- `busy` out 1: high in any state other than IDLE.
- `add`, `remove`, `update`, `op_select`, `we`, `re` out 1 each: datapath strobes.

## Operation
- States: IDLE, WRITE, READ, RDATA. Encoding is free. Outputs are decoded from registered state only; the err outputs are separate registers.
- Eligibility is evaluated only in IDLE:
  - `pe = push_req & ~overflow`
  - `qe = pop_req & ~underflow`
- IDLE transitions:
  - `pe & ~qe` → WRITE.
  - `qe & ~pe` → READ.
  - Both eligible: with `FAIR_ARB=0`, go to WRITE. With `FAIR_ARB=1`, grant the opposite of `last_grant` (1-bit register, updated on every grant, reset to "pop" so the first tie goes to push).
  - Neither eligible → stay in IDLE.
- WRITE: `op_select=0`, `we=1`, `add=1`, `update=1`, `push_ack=1`. Next state is IDLE.
- READ: `op_select=1`, `re=1`, `remove=1`, `update=1`. Next state is RDATA.
- RDATA: `pop_valid=1`, all strobes 0. Next state is IDLE.
- Error pulses are registered:
  - `push_err` is set at the next edge when IDLE samples `push_req & overflow`.
  - `pop_err` is set at the next edge when IDLE samples `pop_req & underflow`.
  - Each clears after one cycle.
  - If a requester holds its request while rejected, it gets one pulse per IDLE cycle.
- An error on one side does not block a grant on the other side in the same cycle.
- Exactly one of `{we, re}` is high in any cycle, or neither. `add` and `remove` are never high together.

## Timing
- Reset: at the edge where `rst=1`, the state goes to IDLE and `last_grant` to pop. All outputs (`push_ack`, `pop_valid`, `push_err`, `pop_err`, `busy`, `add`, `remove`, `update`, `op_select`, `we`, `re`) are 0 from the following cycle.
- Reset mid-operation: an aborted WRITE/READ is discarded. The top level drives the datapath `rst_n` from `~rst`, so pointers and count clear on the same edge.
- Push latency: request sampled at edge k → WRITE during cycle k+1 → IDLE at k+2. Maximum rate is 1 push per 2 cycles.
- Pop latency: request sampled at edge k → READ during cycle k+1 → RDATA (`pop_valid`) during cycle k+2 → IDLE at k+3. The RAM read latency is 1 cycle.
- Flag freshness: the count updates on the WRITE/READ exit edge. Flags sampled in the next IDLE therefore reflect the completed operation, so there is no back-to-back overrun.
- Requesters must deassert their request in the cycle after `push_ack` or `pop_valid`. A request still high in IDLE is treated as a new request.

## Test plan
- Reset with both requests high → all outputs 0, `busy=0`, no strobes for the cycle after reset.
- Push 0x2A into an empty queue → `we`, `add`, `update` high with `op_select=0` for exactly 1 cycle, `push_ack` in the same cycle, `busy` for 1 cycle, and `underflow` deasserts.
- 15 pushes (ADDR_WIDTH=4) → `overflow=1`. A 16th push gives a `push_err` pulse and no `we`. A following pop gives `pop_valid` with the first-pushed value.
- Pop from empty → `pop_err` 1-cycle pulse, no `re`/`remove`, state stays IDLE.
- `push_req` and `pop_req` held together with the queue half full, `FAIR_ARB=1` → grants alternate W, R, W, R. Repeat with `FAIR_ARB=0` → W only until the queue is full, then R.
- `rst` asserted during READ → no `pop_valid` is produced, the count returns to 0, and the next pop gives `pop_err`.
